avr_irq_ctrl: RTL and testbench
===============================

# avr_irq_ctrl

Registered interrupt controller between the AVR core and its peripheral interrupt sources. It replaces the purely combinational priority encoder. It synchronizes raw IRQ lines, latches them as pending in edge or level mode, and masks them through an MMIO enable register. It arbitrates among them and presents a stable `iflag`/`ivect` pair to the core until the core acknowledges the vector.

## Interface
- `NIRQ`, default 4: number of interrupt sources; legal range 1..8.
- `VW`, default 2: vector width; must satisfy 2^VW >= NIRQ. Matches the core's `intr_width`.
- `clk` input 1: system clock, 50 MHz domain.
- `rst` input 1: reset, asynchronous, active-high.
- `irq_in` input NIRQ: raw interrupt requests from peripherals; may be asynchronous.
- `mmio_re` input 1: register read strobe, already qualified by the MMIO slot decode.
- `mmio_we` input 1: register write strobe, already qualified by the MMIO slot decode.
- `mmio_a` input 2: register select.
- `mmio_din` input 8: write data.
- `mmio_dout` output 8: registered read data.
- `iack` input 1: one-cycle pulse from the core when it takes the vector.
- `iflag` output 1: interrupt request to the core.
- `ivect` output VW: vector index, valid while `iflag` is high.

## Operation
- Register map. Bits at or above NIRQ read 0 and ignore writes.
  - 0 ENABLE: R/W mask.
  - 1 PENDING: read gives the pending bits; writing 1 to a bit clears it (edge mode only).
  - 2 EDGE: R/W; 1 selects edge mode, 0 selects level mode.
  - 3 STATUS: read only; bit7 = `iflag`, bits[VW-1:0] = `ivect`.
- Input path: two-flop synchronizer per line, then a one-flop history register for rising-edge detection.
- Edge mode: a synchronized rising edge sets `pending[i]`. The bit clears on acknowledge or on a W1C write. If a set and a clear hit the same cycle, the set wins.
- Level mode: `pending[i]` follows the synchronized level every cycle. W1C writes and acknowledges have no effect.
- `active = pending & enable`.
- Arbitration: the lowest-index active bit wins (see Configuration).
- FSM states: IDLE, REQ, HOLD.
  - IDLE: if `active != 0`, latch the winner into `ivect` and go to REQ.
  - REQ: `iflag` = 1 and `ivect` is frozen, even if a higher-priority source arrives.
    - On `iack`: clear `pending[ivect]` if that source is in edge mode, then go to HOLD.
    - If `active[ivect]` drops with no `iack` (masked, W1C, or level released): go to IDLE with no acknowledge.
    - If `iack` and the withdrawal occur in the same cycle, `iack` wins.
  - HOLD: `iflag` = 0 for exactly one cycle, then IDLE.
  - `iack` seen in IDLE or HOLD is ignored.
- Reset values:
  - All registers, synchronizers, pending bits and FSM state cleared; FSM in IDLE.
  - `iflag` = 0, `ivect` = 0, `mmio_dout` = 0.
  - Reset asserted mid-REQ drops `iflag` immediately; it is asynchronous.

## Timing
- Each `irq_in` line must be high for at least 2 `clk` periods to be guaranteed capture.
- Latency from an `irq_in` rising edge to `pending` set: 3 clocks.
- Latency from `pending`/`enable` becoming active to `iflag` high: 1 clock (IDLE to REQ).
- Total latency from `irq_in` edge to `iflag`: 4 clocks.
- Minimum gap between consecutive vectors is 2 clocks after `iack` (HOLD, then IDLE).
- Reads: `mmio_dout` updates on the clock after `mmio_re` and holds until the next read.
- Writes: take effect on the clock edge where `mmio_we` is sampled. A write to ENABLE affects arbitration on the next cycle.

## Configuration
- `IRQ_ROTATE_EN` defined: round-robin arbitration.
  - A pointer register, reset to 0, advances to `ivect+1` (mod NIRQ) on each `iack`.
  - The winner is the first active bit at or after the pointer, searching cyclically.
- `IRQ_ROTATE_EN` undefined: fixed priority, lowest index wins. No pointer register is built.

## Test plan
- Reset mid-REQ: ENABLE=0x0F, EDGE=0x0F, pulse `irq_in[2]`, assert `rst` on the cycle after `iflag` rises.
  - Required: `iflag`=0, PENDING reads 0x00 after release.
- Edge path: ENABLE=0x0F, EDGE=0x0F, pulse `irq_in[1]` for 2 clocks.
  - Required: `iflag`=1 and `ivect`=1 exactly 4 clocks after the edge.
  - Pulse `iack`: PENDING reads 0x00, `iflag` is low for 1 clock, then stays low.
- Priority and freeze (fixed priority): pending bits 3 and 1 set; `ivect`=1.
  - Raise `irq_in[0]` during REQ: `ivect` stays 1.
  - After `iack`+HOLD: `ivect`=0, then 3.
- Level and mask: EDGE=0x00, hold `irq_in[3]` high.
  - `iack` leaves PENDING=0x08 and `iflag` re-asserts after HOLD.
  - Writing ENABLE=0x00 during REQ drops `iflag` next cycle with no acknowledge.
- Set/clear collision: W1C write to PENDING bit 2 on the same cycle a new edge on bit 2 is detected.
  - Required: PENDING bit 2 reads 1.
- `IRQ_ROTATE_EN`: all 4 lines pending in edge mode, acknowledge each vector as it appears.
  - Required vector order 0,1,2,3.
  - Re-pend all four, then re-pend 0 after the first `iack`: the next winner is 1, not 0.

Source files
------------

// File: rtl/avr_irq_ctrl.sv
// AVR interrupt controller: synchronized, latched and masked IRQ lines with a stable iflag/ivect
// handshake. Define IRQ_ROTATE_EN for round-robin arbitration (fixed lowest-index otherwise).
module avr_irq_ctrl #(
   parameter int unsigned NIRQ = 4,
   parameter int unsigned VW   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NIRQ-1:0] irq_in,
   input  logic            mmio_re,
   input  logic            mmio_we,
   input  logic [1:0]      mmio_a,
   input  logic [7:0]      mmio_din,
   output logic [7:0]      mmio_dout,
   input  logic            iack,
   output logic            iflag,
   output logic [VW-1:0]   ivect
);

   typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

   state_e          state_q, state_d;
   logic [NIRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
   logic [NIRQ-1:0] pending_q, pending_d, enable_q, enable_d, edge_q, edge_d;
   logic [7:0]      dout_q, dout_d;
   logic            iflag_q, iflag_d;
   logic [VW-1:0]   ivect_q, ivect_d;

   logic [NIRQ-1:0] din_n, rise, clr, active, vsel;
   logic            wr_en, wr_pend, wr_edge, ack_take, held;
   logic [VW-1:0]   win;
   logic [7:0]      status;
   logic            unused_din;

   assign unused_din = ^mmio_din;
   assign din_n      = mmio_din[NIRQ-1:0];
   assign wr_en      = mmio_we && (mmio_a == 2'd0);
   assign wr_pend    = mmio_we && (mmio_a == 2'd1);
   assign wr_edge    = mmio_we && (mmio_a == 2'd2);

   assign rise     = sync2_q & ~hist_q;
   assign active   = pending_q & enable_q;
   assign vsel     = NIRQ'(1) << ivect_q;
   assign held     = |(active & vsel);
   assign ack_take = (state_q == StReq) && iack;

   always_comb begin
      sync1_d  = irq_in;
      sync2_d  = sync1_q;
      hist_d   = sync2_q;
      enable_d = wr_en ? din_n : enable_q;
      edge_d   = wr_edge ? din_n : edge_q;
      clr      = (wr_pend ? din_n : '0) | (ack_take ? vsel : '0);
      // Edge-mode bits: a rising edge in the same cycle as a clear keeps the bit set.
      pending_d = (edge_q & ((pending_q & ~clr) | rise)) | (~edge_q & sync2_q);
   end

`ifdef IRQ_ROTATE_EN
   localparam logic [VW:0] NirqW = (VW+1)'(NIRQ);

   logic [VW-1:0]     ptr_q, ptr_d;
   logic [2*NIRQ-1:0] dbl;
   logic [NIRQ-1:0]   rot;
   logic [VW-1:0]     off;
   logic [VW:0]       sum;

   always_comb begin
      dbl = {active, active} >> ptr_q;
      rot = dbl[NIRQ-1:0];
      off = '0;
      for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
         if (rot[i]) off = VW'(i);
      end
      sum = {1'b0, ptr_q} + {1'b0, off};
      if (sum >= NirqW) sum = sum - NirqW;
      win = sum[VW-1:0];
      ptr_d = ptr_q;
      if (ack_take) ptr_d = (ivect_q == VW'(NIRQ - 1)) ? '0 : ivect_q + VW'(1);
   end
`else
   always_comb begin
      win = '0;
      for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
         if (active[i]) win = VW'(i);
      end
   end
`endif

   always_comb begin
      status         = '0;
      status[7]      = iflag_q;
      status[VW-1:0] = ivect_q;
      dout_d         = dout_q;
      if (mmio_re) begin
         case (mmio_a)
            2'd0:    dout_d = 8'(enable_q);
            2'd1:    dout_d = 8'(pending_q);
            2'd2:    dout_d = 8'(edge_q);
            default: dout_d = status;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      iflag_d = iflag_q;
      ivect_d = ivect_q;
      case (state_q)
         StIdle: begin
            if (|active) begin
               ivect_d = win;
               iflag_d = 1'b1;
               state_d = StReq;
            end
         end
         StReq: begin
            // Acknowledge takes precedence over a simultaneous withdrawal.
            if (iack) begin
               iflag_d = 1'b0;
               state_d = StHold;
            end else if (!held) begin
               iflag_d = 1'b0;
               state_d = StIdle;
            end
         end
         StHold: state_d = StIdle;
         default: begin
            iflag_d = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         sync1_q   <= '0;
         sync2_q   <= '0;
         hist_q    <= '0;
         pending_q <= '0;
         enable_q  <= '0;
         edge_q    <= '0;
         dout_q    <= '0;
         iflag_q   <= 1'b0;
         ivect_q   <= '0;
`ifdef IRQ_ROTATE_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         hist_q    <= hist_d;
         pending_q <= pending_d;
         enable_q  <= enable_d;
         edge_q    <= edge_d;
         dout_q    <= dout_d;
         iflag_q   <= iflag_d;
         ivect_q   <= ivect_d;
`ifdef IRQ_ROTATE_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign mmio_dout = dout_q;
   assign iflag     = iflag_q;
   assign ivect     = ivect_q;

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Bench for avr_irq_ctrl: register table, directed corner sequences, and randomized traffic
// checked against a cycle-level reference model of the controller's rules.
module tb_avr_irq_ctrl;
   localparam int NIRQ = 4;
   localparam int VW   = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NIRQ-1:0] irq_in = '0;
   logic            mmio_re = 1'b0, mmio_we = 1'b0, iack = 1'b0;
   logic [1:0]      mmio_a = '0;
   logic [7:0]      mmio_din = '0;
   logic [7:0]      mmio_dout;
   logic            iflag;
   logic [VW-1:0]   ivect;

   always #10 clk = ~clk;

   avr_irq_ctrl #(.NIRQ(NIRQ), .VW(VW)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mmio_re(mmio_re), .mmio_we(mmio_we),
      .mmio_a(mmio_a), .mmio_din(mmio_din), .mmio_dout(mmio_dout), .iack(iack),
      .iflag(iflag), .ivect(ivect)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h, required 0x%02h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: spec rules applied once per clock edge.
   logic [NIRQ-1:0] samp [3];
   logic [NIRQ-1:0] m_pend, m_en, m_edge;
   int              m_state;   // 0 idle, 1 request, 2 hold
   logic            m_flag;
   logic [VW-1:0]   m_vect;
   int              m_ptr;
   logic [7:0]      m_dout;
   bit              chk_en = 1'b0;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) samp[i] = '0;
      m_pend = '0; m_en = '0; m_edge = '0;
      m_state = 0; m_flag = 1'b0; m_vect = '0; m_ptr = 0; m_dout = '0;
   endtask

   task automatic model_step();
      logic [NIRQ-1:0] lvl, rise, act, clr, np;
      int              win, idx;
      bit              any;
      lvl  = samp[1];
      rise = samp[1] & ~samp[2];
      act  = m_pend & m_en;
      any  = 1'b0;
      win  = 0;
      for (int k = 0; k < NIRQ; k++) begin
         idx = (m_ptr + k) % NIRQ;
         if (!any && act[idx]) begin
            any = 1'b1;
            win = idx;
         end
      end
      if (mmio_re) begin
         case (mmio_a)
            2'd0: m_dout = {4'b0, m_en};
            2'd1: m_dout = {4'b0, m_pend};
            2'd2: m_dout = {4'b0, m_edge};
            default: m_dout = {m_flag, 5'b0, m_vect};
         endcase
      end
      clr = (mmio_we && mmio_a == 2'd1) ? mmio_din[NIRQ-1:0] : '0;
      if (m_state == 1 && iack) clr[m_vect] = 1'b1;
      for (int i = 0; i < NIRQ; i++)
         np[i] = m_edge[i] ? ((m_pend[i] && !clr[i]) || rise[i]) : lvl[i];
      case (m_state)
         0: if (any) begin
            m_state = 1; m_flag = 1'b1; m_vect = VW'(win);
         end
         1: if (iack) begin
            m_state = 2; m_flag = 1'b0;
`ifdef IRQ_ROTATE_EN
            m_ptr = (int'(m_vect) + 1) % NIRQ;
`endif
         end else if (!act[m_vect]) begin
            m_state = 0; m_flag = 1'b0;
         end
         default: m_state = 0;
      endcase
      m_pend = np;
      if (mmio_we && mmio_a == 2'd0) m_en = mmio_din[NIRQ-1:0];
      if (mmio_we && mmio_a == 2'd2) m_edge = mmio_din[NIRQ-1:0];
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = irq_in;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rand_iflag", {7'b0, iflag}, {7'b0, m_flag});
         if (m_flag) chk("rand_ivect", {6'b0, ivect}, {6'b0, m_vect});
         chk("rand_dout", mmio_dout, m_dout);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      mmio_we = 1'b1; mmio_a = a; mmio_din = d;
      step(1);
      mmio_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] v);
      mmio_re = 1'b1; mmio_a = a;
      step(1);
      mmio_re = 1'b0;
      v = mmio_dout;
   endtask

   task automatic do_reset();
      irq_in = '0; iack = 1'b0; mmio_we = 1'b0; mmio_re = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   task automatic pulse_ack();
      iack = 1'b1;
      step(1);
      iack = 1'b0;
   endtask

   typedef struct {
      logic [1:0] a;
      logic [7:0] wd;
      logic [7:0] exp;
   } reg_vec_t;

   reg_vec_t   tbl [8];
   logic [7:0] v;

   initial begin
      tbl[0] = '{2'd0, 8'hFF, 8'h0F};
      tbl[1] = '{2'd2, 8'hA5, 8'h05};
      tbl[2] = '{2'd0, 8'h36, 8'h06};
      tbl[3] = '{2'd2, 8'hFA, 8'h0A};
      tbl[4] = '{2'd1, 8'hFF, 8'h00};
      tbl[5] = '{2'd3, 8'hFF, 8'h00};
      tbl[6] = '{2'd0, 8'h00, 8'h00};
      tbl[7] = '{2'd2, 8'h0F, 8'h0F};

      step(2);
      rst = 1'b0;
      step(1);
      chk("reset_iflag", {7'b0, iflag}, 8'h00);
      chk("reset_ivect", {6'b0, ivect}, 8'h00);
      chk("reset_dout", mmio_dout, 8'h00);

      for (int i = 0; i < 8; i++) begin
         wr(tbl[i].a, tbl[i].wd);
         rd(tbl[i].a, v);
         chk("reg_table", v, tbl[i].exp);
      end

      // Reset while a request is presented.
      do_reset();
      wr(2'd0, 8'h0F); wr(2'd2, 8'h0F);
      irq_in[2] = 1'b1; step(2); irq_in = '0; step(2);
      chk("rstreq_iflag_up", {7'b0, iflag}, 8'h01);
      step(1);
      rst = 1'b1;
      #1;
      chk("rstreq_iflag_async", {7'b0, iflag}, 8'h00);
      step(1);
      rst = 1'b0;
      rd(2'd1, v);
      chk("rstreq_pending", v, 8'h00);

      // Edge path latency and acknowledge.
      do_reset();
      wr(2'd0, 8'h0F); wr(2'd2, 8'h0F);
      irq_in[1] = 1'b1; step(2); irq_in = '0; step(1);
      chk("edge_not_early", {7'b0, iflag}, 8'h00);
      step(1);
      chk("edge_iflag", {7'b0, iflag}, 8'h01);
      chk("edge_ivect", {6'b0, ivect}, 8'h01);
      pulse_ack();
      chk("edge_hold_low", {7'b0, iflag}, 8'h00);
      step(1);
      chk("edge_idle_low", {7'b0, iflag}, 8'h00);
      rd(2'd1, v);
      chk("edge_pending_clr", v, 8'h00);
      chk("edge_stays_low", {7'b0, iflag}, 8'h00);

`ifndef IRQ_ROTATE_EN
      // Fixed priority with frozen vector.
      do_reset();
      wr(2'd0, 8'h0F); wr(2'd2, 8'h0F);
      irq_in = 4'b1010; step(2); irq_in = '0; step(2);
      chk("prio_first", {6'b0, ivect}, 8'h01);
      irq_in[0] = 1'b1; step(2); irq_in = '0; step(2);
      chk("prio_frozen", {6'b0, ivect}, 8'h01);
      chk("prio_frozen_flag", {7'b0, iflag}, 8'h01);
      rd(2'd1, v);
      chk("prio_pending", v, 8'h0B);
      pulse_ack(); step(2);
      chk("prio_second_flag", {7'b0, iflag}, 8'h01);
      chk("prio_second", {6'b0, ivect}, 8'h00);
      pulse_ack(); step(2);
      chk("prio_third", {6'b0, ivect}, 8'h03);
      pulse_ack(); step(2);
      chk("prio_done", {7'b0, iflag}, 8'h00);
`else
      // Round-robin ordering.
      do_reset();
      wr(2'd0, 8'h0F); wr(2'd2, 8'h0F);
      irq_in = 4'hF; step(2); irq_in = '0; step(2);
      for (int k = 0; k < NIRQ; k++) begin
         chk("rr_flag", {7'b0, iflag}, 8'h01);
         chk("rr_order", {6'b0, ivect}, 8'(k));
         pulse_ack(); step(2);
      end
      irq_in = 4'hF; step(2); irq_in = '0; step(2);
      chk("rr_again0", {6'b0, ivect}, 8'h00);
      irq_in[0] = 1'b1; step(2); irq_in = '0;
      pulse_ack(); step(2);
      chk("rr_skip0", {6'b0, ivect}, 8'h01);
      rd(2'd1, v);
      chk("rr_pending", v, 8'h0F);
`endif

      // Level mode and masking.
      do_reset();
      wr(2'd0, 8'h0F); wr(2'd2, 8'h00);
      irq_in[3] = 1'b1; step(4);
      chk("lvl_flag", {7'b0, iflag}, 8'h01);
      chk("lvl_vect", {6'b0, ivect}, 8'h03);
      pulse_ack();
      rd(2'd1, v);
      chk("lvl_pending_kept", v, 8'h08);
      step(1);
      chk("lvl_reassert", {7'b0, iflag}, 8'h01);
      wr(2'd0, 8'h00);
      chk("mask_same_cycle", {7'b0, iflag}, 8'h01);
      step(1);
      chk("mask_drop", {7'b0, iflag}, 8'h00);
      step(2);
      chk("mask_stay_low", {7'b0, iflag}, 8'h00);
      irq_in = '0;

      // Set/clear collision on pending bit 2.
      do_reset();
      wr(2'd2, 8'h0F);
      irq_in[2] = 1'b1; step(2);
      wr(2'd1, 8'h04);
      irq_in = '0;
      rd(2'd1, v);
      chk("collide_set_wins", v, 8'h04);
      wr(2'd1, 8'h04);
      chk("dout_holds", mmio_dout, 8'h04);
      rd(2'd1, v);
      chk("w1c_clears", v, 8'h00);

      // Randomized traffic against the model.
      do_reset();
      chk_en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < NIRQ; b++)
            if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
         iack     = iflag ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
         mmio_we  = ($urandom_range(5) == 0);
         mmio_re  = ($urandom_range(2) == 0);
         mmio_a   = 2'($urandom_range(3));
         mmio_din = 8'($urandom);
         if (mmio_we && mmio_a == 2'd0 && $urandom_range(1) == 0) mmio_din[3:0] = 4'hF;
         step(1);
      end
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
